// File: rtl/crc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : crc_pkg
// Purpose  : Shared CRC defaults (width, polynomial, seed) and the receive
//            state encoding used by the serial CRC checker.
// Revision : 1.0  initial release
// ============================================================================
package crc_pkg;

  // Default CRC is x^4 + x + 1 (implicit x^4 term dropped), seeded with zero.
  localparam int         CRC_W_DEF = 4;
  localparam logic [3:0] POLY_DEF  = 4'h3;
  localparam logic [3:0] INIT_DEF  = 4'h0;

  // Receive state encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : crc_pkg
`default_nettype wire

// File: rtl/crc_lfsr_step.sv
`default_nettype none
// ============================================================================
// Module   : crc_lfsr_step
// Purpose  : Combinational single-bit CRC LFSR update. Shared by the serial
//            encoder and checker so both ends use one polynomial definition.
// Revision : 1.0  initial release
// ============================================================================
module crc_lfsr_step
  import crc_pkg::*;
#(
  parameter int               CRC_W = CRC_W_DEF,
  parameter logic [CRC_W-1:0] POLY  = CRC_W'(POLY_DEF)
) (
  input  logic [CRC_W-1:0] lfsr_in,
  input  logic             bit_in,
  output logic [CRC_W-1:0] lfsr_out
);

  logic feedback;

  // Feedback is the outgoing MSB mixed with the incoming bit; when set, the
  // polynomial taps are folded into the shifted register.
  always_comb begin
    feedback = lfsr_in[CRC_W-1] ^ bit_in;
    lfsr_out = {lfsr_in[CRC_W-2:0], 1'b0} ^ (feedback ? POLY : '0);
  end

endmodule : crc_lfsr_step
`default_nettype wire

// File: rtl/crc_check_rx.sv
`default_nettype none
// ============================================================================
// Module   : crc_check_rx
// Purpose  : Serial CRC checker. Receives DATA_W payload bits followed by
//            CRC_W check bits (MSB first), captures the payload, and reports
//            pass/fail with a one-cycle done pulse. A new start-of-frame in
//            the middle of a frame abandons it and pulses abort.
// Revision : 1.0  initial release
// ============================================================================
module crc_check_rx
  import crc_pkg::*;
#(
  parameter int               DATA_W = 8,
  parameter int               CRC_W  = CRC_W_DEF,
  parameter logic [CRC_W-1:0] POLY   = CRC_W'(POLY_DEF),
  parameter logic [CRC_W-1:0] INIT   = CRC_W'(INIT_DEF)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_sof,
  input  logic              i_vld,
  input  logic              i_bit,
  output logic [DATA_W-1:0] o_data,
  output logic              o_crc_ok,
  output logic              o_done,
  output logic              o_abort,
  output logic              o_busy
);

  localparam int               FRAME_LEN = DATA_W + CRC_W;
  localparam int               CNT_W     = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] DATA_CNT  = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_LEN);

  state_t            state;
  state_t            state_next;
  logic [CRC_W-1:0]  lfsr;
  logic [CRC_W-1:0]  lfsr_seed;
  logic [CRC_W-1:0]  lfsr_next;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_base;
  logic [CNT_W-1:0]  cnt_next;
  logic [DATA_W-1:0] payload;
  logic [DATA_W-1:0] payload_shift;
  logic              start;
  logic              accept;
  logic              last_bit;
  logic              in_payload;

  // A valid start-of-frame restarts the frame in any state; other valid bits
  // only count while a frame is in progress.
  always_comb begin
    start      = i_vld & i_sof;
    accept     = start | (i_vld & (state == ST_RECV));
    lfsr_seed  = start ? INIT : lfsr;
    cnt_base   = start ? '0 : cnt;
    cnt_next   = cnt_base + CNT_W'(1);
    in_payload = (cnt_base < DATA_CNT);
    last_bit   = accept & (cnt_next == FRAME_CNT);
  end

  crc_lfsr_step #(
    .CRC_W (CRC_W),
    .POLY  (POLY)
  ) u_step (
    .lfsr_in  (lfsr_seed),
    .bit_in   (i_bit),
    .lfsr_out (lfsr_next)
  );

  if (DATA_W == 1) begin : g_pay_single
    assign payload_shift = i_bit;
  end else begin : g_pay_multi
    assign payload_shift = {payload[DATA_W-2:0], i_bit};
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a frame is at least three bits long, so a start bit can
  // never also be the last bit.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_RECV;
      ST_RECV: begin
        if (start)         state_next = ST_RECV;
        else if (last_bit) state_next = ST_DONE;
      end
      ST_DONE: state_next = start ? ST_RECV : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Frame datapath: LFSR, bit counter, payload capture and result registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lfsr     <= INIT;
      cnt      <= '0;
      payload  <= '0;
      o_data   <= '0;
      o_crc_ok <= 1'b0;
      o_abort  <= 1'b0;
    end else begin
      o_abort <= start & (state == ST_RECV);
      if (accept) begin
        lfsr <= lfsr_next;
        cnt  <= last_bit ? '0 : cnt_next;
        if (in_payload) begin
          payload <= payload_shift;
        end
        if (last_bit) begin
          o_data   <= payload;
          o_crc_ok <= (lfsr_next == '0);
        end
      end
    end
  end

  assign o_done = (state == ST_DONE);
  assign o_busy = (state == ST_RECV);

endmodule : crc_check_rx
`default_nettype wire

// File: tb/tb_crc_check_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_crc_check_rx
// Purpose  : Self-checking bench for crc_check_rx (DATA_W=8, x^4+x+1, INIT=0).
// Revision : 1.0  initial release
// ============================================================================
module tb_crc_check_rx;

  localparam int DATA_W    = 8;
  localparam int CRC_W     = 4;
  localparam int FRAME_LEN = DATA_W + CRC_W;

  logic              clk    = 1'b0;
  logic              rst_n  = 1'b0;
  logic              sof    = 1'b0;
  logic              vld    = 1'b0;
  logic              bit_in = 1'b0;
  logic [DATA_W-1:0] data;
  logic              crc_ok;
  logic              done;
  logic              abort;
  logic              busy;

  int                n_vec = 0;
  int                n_err = 0;
  longint            cyc   = 0;
  longint            done_cyc[$];
  int                abort_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  crc_check_rx #(
    .DATA_W (DATA_W),
    .CRC_W  (CRC_W),
    .POLY   (4'h3),
    .INIT   (4'h0)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_sof    (sof),
    .i_vld    (vld),
    .i_bit    (bit_in),
    .o_data   (data),
    .o_crc_ok (crc_ok),
    .o_done   (done),
    .o_abort  (abort),
    .o_busy   (busy)
  );

  // Remainder of a whole frame divided by x^4+x+1 (long division, INIT=0).
  function automatic logic [3:0] poly_rem(input logic [11:0] f);
    logic [11:0] r;
    r = f;
    for (int i = 11; i >= 4; i--) begin
      if (r[i]) r = r ^ (12'h013 << (i - 4));
    end
    return r[3:0];
  endfunction

  function automatic logic [3:0] crc_for(input logic [7:0] d);
    return poly_rem({d, 4'b0000});
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-level model: collect bits of the current frame, and once a full
  // frame is in hand derive payload and pass/fail by polynomial division.
  logic        m_active = 1'b0;
  logic        m_done   = 1'b0;
  logic        m_abort  = 1'b0;
  logic        m_ok     = 1'b0;
  logic [7:0]  m_data   = 8'h00;
  logic        mq[$];

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_active = 1'b0; m_done = 1'b0; m_abort = 1'b0;
        m_ok = 1'b0; m_data = 8'h00; mq.delete();
      end else begin
        m_done  = 1'b0;
        m_abort = 1'b0;
        if (vld) begin
          if (sof) begin
            if (m_active) m_abort = 1'b1;
            mq.delete();
            mq.push_back(bit_in);
            m_active = 1'b1;
          end else if (m_active) begin
            mq.push_back(bit_in);
          end
        end
        if (m_active && mq.size() == FRAME_LEN) begin
          logic [11:0] f;
          f = '0;
          foreach (mq[i]) f = {f[10:0], mq[i]};
          m_data   = f[11:4];
          m_ok     = (poly_rem(f) == 4'h0);
          m_done   = 1'b1;
          m_active = 1'b0;
          mq.delete();
        end
      end
    end
  end

  // Compare every cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      check("done",   {31'd0, done},   {31'd0, m_done});
      check("abort",  {31'd0, abort},  {31'd0, m_abort});
      check("busy",   {31'd0, busy},   {31'd0, m_active});
      check("data",   {24'd0, data},   {24'd0, m_data});
      check("crc_ok", {31'd0, crc_ok}, {31'd0, m_ok});
      if (done)  done_cyc.push_back(cyc);
      if (abort) abort_cnt++;
    end
  end

  function automatic logic [11:0] frame(input logic [7:0] d, input logic [3:0] c);
    return {d, c};
  endfunction

  // Send the first n bits of a frame, optional 3-cycle gaps after bit ga / gb.
  task automatic send_bits(input logic [11:0] f, input int n, input int ga, input int gb);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      vld    = 1'b1;
      sof    = (i == 0);
      bit_in = f[11-i];
      if (i + 1 == ga || i + 1 == gb) begin
        for (int g = 0; g < 3; g++) begin
          @(negedge clk);
          vld = 1'b0;
          sof = 1'b0;
          check("gap_busy", {31'd0, busy}, 32'd1);
        end
      end
    end
  endtask

  task automatic wait_done(output int lat);
    bit found;
    found = 1'b0;
    lat   = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      vld = 1'b0;
      sof = 1'b0;
      if (done) begin
        found = 1'b1;
        lat   = k;
        break;
      end
    end
    check("done_seen", {31'd0, found}, 32'd1);
  endtask

  initial begin
    int    lat;
    int    n_abort0;
    int    n_done0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_data", {24'd0, data}, 32'd0);
    check("rst_ok",   {31'd0, crc_ok}, 32'd0);
    #2 rst_n = 1'b1;

    // Pin the model against hand-computed check values
    check("model_crc_a5", {28'd0, crc_for(8'hA5)}, 32'hB);
    check("model_crc_3c", {28'd0, crc_for(8'h3C)}, 32'h8);

    // Good frame
    send_bits(frame(8'hA5, 4'b1011), FRAME_LEN, -1, -1);
    wait_done(lat);
    check("good_lat",  lat, 32'd1);
    check("good_data", {24'd0, data}, 32'hA5);
    check("good_ok",   {31'd0, crc_ok}, 32'd1);

    // Corrupted frame
    send_bits(frame(8'hA5, 4'b1010), FRAME_LEN, -1, -1);
    wait_done(lat);
    check("bad_lat",  lat, 32'd1);
    check("bad_data", {24'd0, data}, 32'hA5);
    check("bad_ok",   {31'd0, crc_ok}, 32'd0);

    // Gapped input
    send_bits(frame(8'hA5, 4'b1011), FRAME_LEN, 2, 9);
    wait_done(lat);
    check("gap_lat",  lat, 32'd1);
    check("gap_data", {24'd0, data}, 32'hA5);
    check("gap_ok",   {31'd0, crc_ok}, 32'd1);

    // Abort after 5 bits, then a full 0x3C frame
    @(negedge clk);
    n_abort0 = abort_cnt;
    n_done0  = done_cyc.size();
    send_bits(frame(8'hA5, 4'b1011), 5, -1, -1);
    send_bits(frame(8'h3C, 4'b1000), FRAME_LEN, -1, -1);
    wait_done(lat);
    @(negedge clk);
    check("abort_pulses", abort_cnt - n_abort0, 32'd1);
    check("abort_dones",  done_cyc.size() - n_done0, 32'd1);
    check("abort_data",   {24'd0, data}, 32'h3C);
    check("abort_ok",     {31'd0, crc_ok}, 32'd1);

    // Back-to-back frames, second sof in the DONE cycle
    n_done0 = done_cyc.size();
    send_bits(frame(8'hA5, 4'b1011), FRAME_LEN, -1, -1);
    send_bits(frame(8'h3C, 4'b1000), FRAME_LEN, -1, -1);
    wait_done(lat);
    @(negedge clk);
    check("b2b_dones", done_cyc.size() - n_done0, 32'd2);
    if (done_cyc.size() >= 2)
      check("b2b_spacing", 32'(done_cyc[$] - done_cyc[$-1]), 32'd12);
    check("b2b_data", {24'd0, data}, 32'h3C);
    check("b2b_ok",   {31'd0, crc_ok}, 32'd1);

    // Reset mid-frame after 6 bits
    n_done0 = done_cyc.size();
    send_bits(frame(8'h3C, 4'b1000), 6, -1, -1);
    @(negedge clk);
    vld = 1'b0;
    sof = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_data", {24'd0, data}, 32'd0);
    check("mrst_ok",   {31'd0, crc_ok}, 32'd0);
    check("mrst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("mrst_no_done", done_cyc.size() - n_done0, 32'd0);
    send_bits(frame(8'hA5, 4'b1011), FRAME_LEN, -1, -1);
    wait_done(lat);
    check("post_rst_data", {24'd0, data}, 32'hA5);
    check("post_rst_ok",   {31'd0, crc_ok}, 32'd1);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_crc_check_rx
`default_nettype wire

// File: doc/crc_check_rx.md
Name: crc_check_rx

Overview:
- Serial CRC checker that sits directly downstream of the serial CRC encoder.
- Receives a frame serially, MSB first: DATA_W payload bits followed by CRC_W check bits.
- Deserialises the payload, runs the same LFSR over the whole frame, and reports pass/fail with a one-cycle done pulse.
- Feeds the frame-level consumer (statistics / payload sink).

Parameters:
- DATA_W, 8, payload bits per frame (>=1).
- CRC_W, 4, CRC width / LFSR length (2..32).
- POLY, 4'h3, generator polynomial without the implicit x^CRC_W term; default is x^4+x+1. Width is CRC_W.
- INIT, 4'h0, LFSR value loaded at start of frame. Width is CRC_W.

Ports:
- i_clk, input, 1, system clock, rising edge.
- i_rst_n, input, 1, asynchronous active-low reset.
- i_sof, input, 1, marks the first bit of a frame; sampled only when i_vld=1.
- i_vld, input, 1, i_bit is valid this cycle.
- i_bit, input, 1, serial frame bit, MSB first.
- o_data, output, DATA_W, captured payload; stable from o_done until the next o_done.
- o_crc_ok, output, 1, 1 = frame remainder zero; valid with o_done, held until the next o_done.
- o_done, output, 1, one-cycle pulse when the frame check completes.
- o_abort, output, 1, one-cycle pulse when a frame is cut short by a new i_sof.
- o_busy, output, 1, high while a frame is in progress.

Behaviour:
- Reset (asynchronous, i_rst_n=0): state IDLE; LFSR=INIT; bit counter=0; o_data=0; o_crc_ok=0; o_done=0; o_abort=0; o_busy=0.
- States:
  - IDLE: waits for i_vld & i_sof.
  - RECV: shifts in bits.
  - DONE: one cycle; drives the o_done pulse, then returns to IDLE.
- IDLE -> RECV on i_vld & i_sof:
  - that bit is processed as frame bit 0;
  - LFSR is seeded from INIT, then the bit is applied;
  - counter = 1.
- Bits with i_vld=1 and i_sof=0 in IDLE are discarded.
- LFSR step for each valid bit b:
  - fb = lfsr[CRC_W-1] ^ b;
  - lfsr = {lfsr[CRC_W-2:0], 1'b0} ^ (fb ? POLY : 0).
- RECV:
  - each cycle with i_vld=1 applies one bit and increments the counter;
  - i_vld=0 holds all state (gaps of any length allowed);
  - while counter < DATA_W, the bit is also shifted into the payload shift register (left shift, MSB first).
- RECV -> DONE when the bit that makes counter = DATA_W+CRC_W is applied. On that cycle:
  - the payload register is copied to o_data;
  - o_crc_ok is registered as (next lfsr == 0).
- DONE:
  - o_done=1 for exactly one cycle, in the cycle after the last bit (latency 1 clock from the last valid bit);
  - o_busy=0; then go to IDLE.
- A bit with i_vld & i_sof arriving during DONE starts a new frame immediately (DONE -> RECV). Back-to-back frames need no gap.
- i_sof & i_vld during RECV:
  - the current frame is abandoned; o_abort pulses for one cycle in the next cycle;
  - this bit restarts as bit 0 of a new frame;
  - o_data and o_crc_ok are not updated; o_done is not asserted.
- o_busy = 1 in RECV; 0 in IDLE and DONE.
- Counter width is $clog2(DATA_W+CRC_W+1). The counter cannot wrap within a frame.
- i_rst_n asserted mid-frame: immediate return to the reset state; the partial frame is lost with no done and no abort.
- With INIT=0, an all-zero frame yields ok=1.

Decomposition:
- Shared package crc_pkg holds:
  - default CRC_W, POLY and INIT constants;
  - state encoding localparams (ST_IDLE, ST_RECV, ST_DONE).
- One natural sub-module, crc_lfsr_step: combinational single-bit LFSR update, parameterised by CRC_W and POLY.
- The serial encoder should instantiate crc_lfsr_step too, so both ends share one polynomial definition.

Test Plan:
- Good frame: send 0xA5 then CRC 4'b1011 (x^4+x+1, INIT=0), contiguous i_vld, i_sof on the first bit -> o_done pulses 1 cycle after the 12th bit; o_data=8'hA5; o_crc_ok=1.
- Corrupted frame: same as above but CRC 4'b1010 -> o_done=1, o_crc_ok=0, o_data=8'hA5.
- Gapped input: same good frame with i_vld low for 3 cycles after bits 2 and 9 -> identical result; o_busy high throughout the frame including the gaps.
- Abort: i_sof after 5 bits, then a full 0x3C frame with its correct CRC -> o_abort pulses once, no o_done for the first frame; the second frame gives o_data=8'h3C, o_crc_ok=1.
- Back-to-back frames: second i_sof in the DONE cycle -> two o_done pulses exactly 12 cycles apart, both checked correctly.
- Reset mid-frame: i_rst_n low for 2 cycles after bit 6 -> outputs return to reset values at once, no o_done; the next good frame is checked correctly.
